// File: rtl/insn_seq_fetch.sv
// Instruction fetch and phase sequencer feeding the instruction-class decoder.
// Optional trap-on-illegal behaviour and the `illegal` port are enabled by defining INSN_SEQ_TRAP_EN.

module insn_seq_fetch #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        run,
  input  logic [31:0] imem_data,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] INSN,
  output logic [9:0]  Code,
  output logic        insn_clk,
  output logic        pc_en,
  output logic        busy
`ifdef INSN_SEQ_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
`ifdef INSN_SEQ_TRAP_EN
  localparam logic [2:0] ST_HALT   = 3'd5;
`endif

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  function automatic logic [9:0] classify(input logic [6:0] opcode);
    logic [9:0] code_v;
    case (opcode)
      7'b0000011: code_v = 10'h100;
      7'b0010011: code_v = 10'h080;
      7'b0100011: code_v = 10'h040;
      7'b0110011: code_v = 10'h020;
      7'b1100011: code_v = 10'h010;
      7'b0010111: code_v = 10'h008;
      7'b0110111: code_v = 10'h004;
      7'b1100111: code_v = 10'h002;
      7'b1101111: code_v = 10'h001;
      default:    code_v = 10'h200;
    endcase
    return code_v;
  endfunction

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic [9:0] class_s;
  logic       busy_nxt_s;

  assign class_s = classify(INSN[6:0]);

  // Next-state and exec-counter logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack) state_nxt_s = ST_DECODE;
        else          state_nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        cnt_nxt_s = 4'd0;
`ifdef INSN_SEQ_TRAP_EN
        if (class_s[9]) state_nxt_s = ST_HALT;
        else            state_nxt_s = ST_EXEC;
`else
        state_nxt_s = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        if (cnt_r == EXEC_LAST) begin
          state_nxt_s = ST_COMMIT;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_EXEC;
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      ST_COMMIT: begin
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
`ifdef INSN_SEQ_TRAP_EN
      ST_HALT: state_nxt_s = ST_HALT;
`endif
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
`ifdef INSN_SEQ_TRAP_EN
    busy_nxt_s = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HALT);
`else
    busy_nxt_s = (state_nxt_s != ST_IDLE);
`endif
  end

  // State, captured instruction/class and registered phase outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      imem_req <= 1'b0;
      INSN     <= 32'd0;
      Code     <= 10'd0;
      insn_clk <= 1'b0;
      pc_en    <= 1'b0;
      busy     <= 1'b0;
`ifdef INSN_SEQ_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      imem_req <= (state_nxt_s == ST_FETCH);
      // Counter value 0 keeps the strobe low so operands settle before the rising edge.
      insn_clk <= (state_nxt_s == ST_EXEC) && (cnt_nxt_s != 4'd0);
      pc_en    <= (state_nxt_s == ST_COMMIT);
      busy     <= busy_nxt_s;
      if (state_r == ST_FETCH && imem_ack) INSN <= imem_data;
      if (state_r == ST_DECODE) Code <= class_s;
`ifdef INSN_SEQ_TRAP_EN
      if (state_r == ST_DECODE && class_s[9]) illegal <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/insn_seq_fetch.md
# insn_seq_fetch

Instruction fetch and phase sequencer placed directly upstream of the instruction-class control decoder. It fetches a 32-bit instruction over a req/ack handshake and registers it as `INSN`. It classifies the opcode into the 10-bit one-hot `Code` bus and generates the `insn_clk` phase strobe. That strobe is the `CLK` input the decoder gates into `rd_clk`/`mem_clk`. One `pc_en` pulse per retired instruction advances the PC.

## Interface
- `EXEC_CYCLES`, default 2: length of EXEC state in cycles; legal range 2..15.
- `CLK`  in  1  system clock, all state on rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `run`  in  1  enable sequencing; sampled in IDLE and COMMIT.
- `imem_data`  in  32  instruction word, valid when `imem_ack`=1.
- `imem_ack`  in  1  memory acknowledge; ignored unless `imem_req`=1.
- `imem_req`  out  1  fetch request.
- `INSN`  out  32  registered instruction.
- `Code`  out  10  one-hot class: [9] illegal, [8] load 0000011, [7] I-ALU 0010011, [6] store 0100011, [5] R 0110011, [4] branch 1100011, [3] auipc 0010111, [2] lui 0110111, [1] jalr 1100111, [0] jal 1101111.
- `insn_clk`  out  1  phase strobe to the decoder `CLK`.
- `pc_en`  out  1  one-cycle PC advance pulse.
- `busy`  out  1  high in any state except IDLE/HALT.
- `illegal`  out  1  sticky illegal-opcode flag; present only with `INSN_SEQ_TRAP_EN`.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, COMMIT, HALT (HALT only with the macro).
- IDLE: if `run`=1, go to FETCH next cycle.
- FETCH: `imem_req`=1.
  - On a cycle with `imem_ack`=1, capture `imem_data` into `INSN`, go to DECODE.
  - Wait indefinitely otherwise; no timeout.
- DECODE (1 cycle): register `Code` from `INSN[6:0]`.
  - Exactly one bit is set.
  - Any unlisted opcode, including `INSN[1:0]`≠2'b11, sets `Code[9]`.
- EXEC: exec counter runs 0..EXEC_CYCLES-1.
  - `insn_clk`=0 while the counter is 0, so operands settle.
  - `insn_clk`=1 for counter ≥1, so the rising edge feeds the downstream decoder.
- COMMIT (1 cycle): `insn_clk`=0, `pc_en`=1. Next state is FETCH if `run`=1, else IDLE.
- `run` deasserted mid-instruction: the current instruction completes through COMMIT, then IDLE.
- `Code`/`INSN` hold their values from DECODE until the next DECODE/FETCH capture.
- A new `INSN` is captured in FETCH while `Code` still holds the previous class. The downstream decoder is gated by `insn_clk`=0 at that time.

## Timing
- Reset values: `imem_req`=0, `INSN`=0, `Code`=0, `insn_clk`=0, `pc_en`=0, `busy`=0, `illegal`=0; state IDLE.
- All outputs are registered.
- `RST_N` low mid-operation returns to IDLE immediately, even with `imem_req` high. A late `imem_ack` is then ignored.
- Per-instruction latency is FETCH wait + 1 (DECODE) + EXEC_CYCLES + 1 (COMMIT).
  - With same-cycle ack and EXEC_CYCLES=2: 5 cycles from FETCH entry to `pc_en`.
- `insn_clk` high time is EXEC_CYCLES-1 cycles; `pc_en` never overlaps `insn_clk`=1.
- Back-to-back instructions: `imem_req` rises in the cycle after COMMIT.

## Configuration
- `INSN_SEQ_TRAP_EN` defined: `Code[9]` in DECODE causes the following.
  - Set `illegal`, skip EXEC/COMMIT (no `insn_clk` edge, no `pc_en`), enter HALT.
  - HALT is left only via `RST_N`.
- Undefined: `illegal` port absent; `Code[9]` instructions run normally as NOPs.
  - The decoder's class-9 input is tied low, so `insn_clk` produces no writes.
  - `pc_en` still pulses.

## Test plan
- Reset then `run`=1, `imem_data`=0x00500093 (addi), ack same cycle -> `Code`=10'h080; `insn_clk` high 1 cycle; `pc_en` in cycle 5 after FETCH entry.
- Fetch 0x0000006F (jal) with ack delayed 3 cycles -> `imem_req` high 4 cycles; `Code`=10'h001; `pc_en` in cycle 8.
- EXEC_CYCLES=4, 0x00A12023 (sw) -> `Code`=10'h040; `insn_clk` high exactly 3 cycles; `pc_en` follows with no overlap.
- 0xFFFFFFFF with macro -> `illegal`=1, `Code`=10'h200, no `pc_en`, `busy`=0 in HALT. Without macro -> `pc_en` pulses and fetch continues.
- `RST_N` low while FETCH waits -> `imem_req`=0 immediately; ack next cycle leaves `INSN`=0 and `Code`=0.
- `run` dropped during EXEC of lui 0x123450B7 -> `Code`=10'h004; single `pc_en`; IDLE with `busy`=0.
